fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter HANDLER_ADDR, default 32'h0000_4180, exception/interrupt handler entry address.
REQ-002 The block SHALL have parameter RESET_ADDR, default 32'h0000_3000, the reset value of epc.
REQ-003 The block SHALL have the following ports:
  clk  in  1  single clock; all state updates on rising edge.
  rst  in  1  asynchronous, active-low reset.
  stall  in  1  hazard-unit freeze request for the fetch stage.
  br_taken  in  1  control-flow redirect resolved this cycle.
  br_target  in  32  redirect target address.
  exc_req  in  1  synchronous exception flagged by the M-stage instruction.
  exc_pc  in  32  PC of the M-stage instruction.
  exc_bd  in  1  M-stage instruction sits in a branch delay slot.
  hw_int  in  6  hardware interrupt lines, level-sensitive.
  int_mask  in  6  per-line interrupt enable.
  eret  in  1  eret present in the M stage.
  pcen  out  1  PC register update enable.
  br  out  1  PC loads npc (1) or pc+4 (0).
  npc  out  32  next-PC value.
  j2intpro  out  1  PC loads HANDLER_ADDR.
  flush  out  1  kill F/D/E pipeline registers.
  epc  out  32  saved return address.
  exl  out  1  exception level; 1 while in the handler.
  state  out  2  current FSM state.

Function
REQ-004 The FSM SHALL have four states: RUN=2'd0, ENTER=2'd1, HANDLER=2'd2, RETURN=2'd3.
REQ-005 int_pend SHALL be |(hw_int & int_mask) & ~exl.
REQ-006 In RUN with no event taken: pcen=~stall, br=br_taken, npc=br_target, j2intpro=0, flush=0.
REQ-007 In RUN, when exc_req or int_pend is 1, the event SHALL be taken regardless of stall. In that cycle: pcen=0, br=0, flush=1. Next state is ENTER.
REQ-008 On the taking edge, epc SHALL load exc_bd ? exc_pc-4 : exc_pc (mod 2^32), and exl SHALL be set to 1.
REQ-009 In ENTER: j2intpro=1, pcen=1, flush=1, br=0, for exactly one cycle; stall is ignored. Next state is HANDLER.
REQ-010 In HANDLER, outputs SHALL follow REQ-006. exc_req and hw_int SHALL be ignored: no epc update and no state change.
REQ-011 In HANDLER, eret=1 with stall=0 SHALL move the FSM to RETURN; eret with stall=1 SHALL be held off until stall drops.
REQ-012 In RETURN: br=1, npc=epc, pcen=1, flush=1, j2intpro=0, for exactly one cycle. exl SHALL clear on the exiting edge. Next state is RUN.
REQ-013 In RUN, eret SHALL be ignored (no redirect, exl stays 0).
REQ-014 Priority in RUN SHALL be: exc_req/int_pend > br_taken > stall.
REQ-015 In HANDLER, eret SHALL take priority over exc_req in the same cycle.
REQ-016 Only one of j2intpro and br=1-with-npc=epc SHALL be asserted in any cycle.
REQ-017 pcen, br, npc, j2intpro and flush SHALL be combinational from state and inputs. epc, exl and state SHALL be registered.
REQ-018 An interrupt that is still asserted when RETURN completes SHALL be taken in the first RUN cycle, with epc loaded per REQ-008.

Reset
REQ-019 While rst=0, the block SHALL hold: state=RUN, exl=0, epc=RESET_ADDR, pcen=0, br=0, j2intpro=0, flush=0, npc=br_target.
REQ-020 Reset assertion SHALL take effect asynchronously from any state, including ENTER and RETURN, abandoning the event in progress. Deassertion SHALL be sampled on the next rising clk.

Verification
REQ-021 Interrupt entry: RUN, int_mask=6'h01, hw_int=6'h01, exc_pc=32'h3010, exc_bd=0 -> epc=32'h3010, exl=1, next cycle ENTER with j2intpro=1, flush=1, then HANDLER.
REQ-022 Delay-slot exception: exc_req=1, exc_pc=32'h3024, exc_bd=1, stall=1 -> event still taken, epc=32'h3020.
REQ-023 Masked and nested: int_mask=0 with hw_int=6'h3F -> stays in RUN. In HANDLER, exc_req=1 -> epc unchanged, state HANDLER.
REQ-024 Return: HANDLER, epc=32'h3010, eret=1, stall=1 for 2 cycles then 0 -> RETURN one cycle with br=1, npc=32'h3010, then RUN with exl=0.
REQ-025 Collision: RUN, br_taken=1, br_target=32'h3100, exc_req=1 -> br=0, flush=1, next ENTER. Later eret and exc_req together in HANDLER -> RETURN.
REQ-026 Async reset: rst=0 mid-ENTER, between clock edges -> immediately state=RUN, exl=0, epc=32'h3000, j2intpro=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC controller: steers the PC between sequential, branch, handler
// entry and exception return, and keeps the saved return address / exception level.
module fetch_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] RESET_ADDR   = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [5:0]  hw_int,
  input  logic [5:0]  int_mask,
  input  logic        eret,
  output logic        pcen,
  output logic        br,
  output logic [31:0] npc,
  output logic        j2intpro,
  output logic        flush,
  output logic [31:0] epc,
  output logic        exl,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ENTER   = 2'd1,
    HANDLER = 2'd2,
    RETURN  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] epc_reg, epc_next;
  logic        exl_reg, exl_next;
  logic [5:0]  line_pend;
  logic        int_pend;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_line
      assign line_pend[gi] = hw_int[gi] & int_mask[gi];
    end
  endgenerate

  // Interrupts are blocked while already inside the handler.
  assign int_pend = (|line_pend) & ~exl_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RUN;
      epc_reg   <= RESET_ADDR;
      exl_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      epc_reg   <= epc_next;
      exl_reg   <= exl_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    epc_next   = epc_reg;
    exl_next   = exl_reg;
    pcen       = 1'b0;
    br         = 1'b0;
    npc        = br_target;
    j2intpro   = 1'b0;
    flush      = 1'b0;

    if (rst) begin
      unique case (state_reg)
        RUN: begin
          if (exc_req || int_pend) begin
            flush      = 1'b1;
            state_next = ENTER;
            epc_next   = exc_bd ? (exc_pc - 32'd4) : exc_pc;
            exl_next   = 1'b1;
          end else begin
            pcen = ~stall;
            br   = br_taken;
          end
        end
        ENTER: begin
          j2intpro   = 1'b1;
          pcen       = 1'b1;
          flush      = 1'b1;
          state_next = HANDLER;
        end
        HANDLER: begin
          pcen = ~stall;
          br   = br_taken;
          if (eret && !stall) begin
            state_next = RETURN;
          end
        end
        RETURN: begin
          br         = 1'b1;
          npc        = epc_reg;
          pcen       = 1'b1;
          flush      = 1'b1;
          exl_next   = 1'b0;
          state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  assign epc   = epc_reg;
  assign exl   = exl_reg;
  assign state = state_reg;

endmodule
